// File: rtl/q65_bus_arbiter_pkg.sv
// Shared types and the round-robin search used by the q65 bus arbiter.
// Widths are sized for the largest supported source count (8).
package q65_bus_pkg;

    typedef enum logic [1:0] {KEEP, DEAD, OWN} state_t;

    localparam int MAX_SRC = 8;
    localparam int IDX_W   = $clog2(MAX_SRC);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping within the nsrc live sources.
    function automatic pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 nsrc);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            if (k < nsrc) begin
                j = int'(ptr) + k;
                if (j >= nsrc) j = j - nsrc;
                if (!res.found && req[j]) begin
                    res.found = 1'b1;
                    res.idx   = IDX_W'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/q65_bus_arbiter_if.sv
// Request/enable bundle between the q65 bus sources and the arbiter.
interface q65_bus_arbiter_if #(
    parameter int NSRC = 4,
    parameter int DW   = 8
);
    import q65_bus_pkg::*;

    logic [NSRC-1:0]         req;
    logic                    lock;
    logic [DW-1:0]           bus_in;
    logic [NSRC-1:0]         grant_en;
    logic                    keep_en;
    logic [DW-1:0]           keep_data;
    logic [$clog2(NSRC)-1:0] owner;
    logic                    busy;

    modport master (
        output req, lock, bus_in,
        input  grant_en, keep_en, keep_data, owner, busy
    );

    modport slave (
        input  req, lock, bus_in,
        output grant_en, keep_en, keep_data, owner, busy
    );

endinterface

// File: rtl/q65_bus_arbiter_rr_pick.sv
// Combinational round-robin picker wrapping the package search function.
module q65_rr_pick
    import q65_bus_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int OW   = 2
) (
    input  logic [NSRC-1:0] i_req,
    input  logic [OW-1:0]   i_ptr,
    output logic            o_found,
    output logic [OW-1:0]   o_idx
);

    pick_t            w_pick;
    logic [IDX_W:0]   w_unused_pick;

    assign w_pick        = rr_pick(MAX_SRC'(i_req), IDX_W'(i_ptr), NSRC);
    assign o_found       = w_pick.found;
    assign o_idx         = w_pick.idx[OW-1:0];
    // Upper index bits are always zero when fewer than MAX_SRC sources exist.
    assign w_unused_pick = w_pick;

endmodule

// File: rtl/q65_bus_arbiter.sv
// Break-before-make arbiter for the shared q65 bus: one-hot driver enables,
// a dead gap on every owner change, and a keeper that re-drives the last owned value.
module q65_bus_arbiter
    import q65_bus_pkg::*;
#(
    parameter int NSRC        = 4,
    parameter int DW          = 8,
    parameter int DEAD_CYCLES = 1
) (
    input logic              clk,
    input logic              rst_n,
    q65_bus_arbiter_if.slave arb
);

    localparam int            OW        = $clog2(NSRC);
    localparam logic [OW-1:0] LAST_IDX  = OW'(NSRC - 1);
    localparam logic [1:0]    DEAD_LAST = 2'(DEAD_CYCLES - 1);

    state_t          r_state, w_next_state;
    logic [OW-1:0]   r_owner, w_owner_d;
    logic [OW-1:0]   r_target, w_target_d;
    logic [OW-1:0]   r_rr_ptr, w_rr_d;
    logic            r_tgt_valid, w_tgt_valid_d;
    logic [1:0]      r_dead_cnt, w_dead_d;
    logic [NSRC-1:0] r_grant_en;
    logic            r_keep_en;
    logic            r_busy;
    logic [DW-1:0]   r_keep_data;
    logic [NSRC-1:0] w_owner_mask;
    logic [NSRC-1:0] w_pick_req;
    logic            w_found;
    logic [OW-1:0]   w_pick_idx;

    // While owning, the owner itself is excluded so the picker finds a challenger.
    assign w_owner_mask = NSRC'(1) << r_owner;
    assign w_pick_req   = (r_state == OWN) ? (arb.req & ~w_owner_mask) : arb.req;

    q65_rr_pick #(
        .NSRC (NSRC),
        .OW   (OW)
    ) u_pick (
        .i_req   (w_pick_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_next_state  = r_state;
        w_owner_d     = r_owner;
        w_target_d    = r_target;
        w_tgt_valid_d = r_tgt_valid;
        w_rr_d        = r_rr_ptr;
        w_dead_d      = r_dead_cnt;
        unique case (r_state)
            KEEP: begin
                if (w_found) begin
                    w_next_state  = DEAD;
                    w_target_d    = w_pick_idx;
                    w_tgt_valid_d = 1'b1;
                    w_dead_d      = '0;
                end
            end
            DEAD: begin
                if (r_dead_cnt == DEAD_LAST) begin
                    w_dead_d = '0;
                    // A target that dropped its request during the gap is never granted.
                    if (r_tgt_valid && arb.req[r_target]) begin
                        w_next_state = OWN;
                        w_owner_d    = r_target;
                        w_rr_d       = (r_target == LAST_IDX) ? '0 : r_target + OW'(1);
                    end else begin
                        w_next_state = KEEP;
                    end
                end else begin
                    w_dead_d = r_dead_cnt + 2'd1;
                end
            end
            OWN: begin
                if (!arb.req[r_owner]) begin
                    w_next_state  = DEAD;
                    w_target_d    = w_pick_idx;
                    w_tgt_valid_d = w_found;
                    w_dead_d      = '0;
                end else if (w_found && !arb.lock) begin
                    w_next_state  = DEAD;
                    w_target_d    = w_pick_idx;
                    w_tgt_valid_d = 1'b1;
                    w_dead_d      = '0;
                end
            end
            default: w_next_state = KEEP;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= KEEP;
            r_owner     <= '0;
            r_target    <= '0;
            r_tgt_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_dead_cnt  <= '0;
            r_grant_en  <= '0;
            r_keep_en   <= 1'b1;
            r_busy      <= 1'b0;
            r_keep_data <= '0;
        end else begin
            r_state     <= w_next_state;
            r_owner     <= w_owner_d;
            r_target    <= w_target_d;
            r_tgt_valid <= w_tgt_valid_d;
            r_rr_ptr    <= w_rr_d;
            r_dead_cnt  <= w_dead_d;
            r_grant_en  <= (w_next_state == OWN) ? (NSRC'(1) << w_owner_d) : '0;
            r_keep_en   <= (w_next_state == KEEP);
            r_busy      <= (w_next_state == OWN);
            if (r_state == OWN) r_keep_data <= arb.bus_in;
        end
    end

    assign arb.grant_en  = r_grant_en;
    assign arb.keep_en   = r_keep_en;
    assign arb.keep_data = r_keep_data;
    assign arb.owner     = r_owner;
    assign arb.busy      = r_busy;

endmodule

// File: tb/tb_q65_bus_arbiter.sv
// Directed bench for q65_bus_arbiter: one instance with a single dead cycle,
// one with three, plus per-cycle enable-overlap and dead-gap checks on both.
module tb_q65_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    q65_bus_arbiter_if #(.NSRC(4), .DW(8)) busA ();
    q65_bus_arbiter_if #(.NSRC(4), .DW(8)) busB ();

    q65_bus_arbiter #(.NSRC(4), .DW(8), .DEAD_CYCLES(1)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (busA)
    );

    q65_bus_arbiter #(.NSRC(4), .DW(8), .DEAD_CYCLES(3)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (busB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit toB, input logic [3:0] req,
                                 input logic lock, input logic [7:0] data);
        if (toB) begin
            busB.req = req; busB.lock = lock; busB.bus_in = data;
        end else begin
            busA.req = req; busA.lock = lock; busA.bus_in = data;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(0, 4'b0000, 1'b0, 8'h00);
        applyStimulus(1, 4'b0000, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Enables never overlap, and a grant never moves between sources without an all-zero cycle.
    logic [3:0] prevA = '0, prevB = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("onehotA", 32'($onehot0({busA.grant_en, busA.keep_en})), 32'd1);
            checkOutput("onehotB", 32'($onehot0({busB.grant_en, busB.keep_en})), 32'd1);
            checkOutput("gapA", 32'(prevA != 0 && busA.grant_en != 0 && busA.grant_en != prevA), 32'd0);
            checkOutput("gapB", 32'(prevB != 0 && busB.grant_en != 0 && busB.grant_en != prevB), 32'd0);
        end
        prevA = busA.grant_en;
        prevB = busB.grant_en;
    end

    logic [3:0] rotGrant [10];
    logic [1:0] rotOwner [10];

    initial begin
        rotGrant = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        rotOwner = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
        applyStimulus(0, 4'b0000, 1'b0, 8'h00);
        applyStimulus(1, 4'b0000, 1'b0, 8'h00);

        // Reset state, then idle keeper for 10 cycles.
        #12;
        checkOutput("rst_keep", 32'(busA.keep_en), 32'd1);
        checkOutput("rst_grant", 32'(busA.grant_en), 32'd0);
        checkOutput("rst_busy", 32'(busA.busy), 32'd0);
        checkOutput("rst_owner", 32'(busA.owner), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("idle_keep", 32'(busA.keep_en), 32'd1);
            checkOutput("idle_grant", 32'(busA.grant_en), 32'd0);
            checkOutput("idle_data", 32'(busA.keep_data), 32'h00);
        end
        checkOutput("idleB_keep", 32'(busB.keep_en), 32'd1);

        // Single request, keeper capture and re-drive.
        applyStimulus(0, 4'b0001, 1'b0, 8'h00);
        tick(1);
        checkOutput("t2_dead_keep", 32'(busA.keep_en), 32'd0);
        checkOutput("t2_dead_grant", 32'(busA.grant_en), 32'd0);
        tick(1);
        checkOutput("t2_own_grant", 32'(busA.grant_en), 32'h1);
        checkOutput("t2_own_busy", 32'(busA.busy), 32'd1);
        checkOutput("t2_own_owner", 32'(busA.owner), 32'd0);
        applyStimulus(0, 4'b0001, 1'b0, 8'hA5);
        tick(1);
        applyStimulus(0, 4'b0000, 1'b0, 8'hA5);
        tick(1);
        checkOutput("t2_rel_grant", 32'(busA.grant_en), 32'd0);
        checkOutput("t2_rel_keep", 32'(busA.keep_en), 32'd0);
        tick(1);
        checkOutput("t2_keep_en", 32'(busA.keep_en), 32'd1);
        checkOutput("t2_keep_data", 32'(busA.keep_data), 32'hA5);
        applyStimulus(0, 4'b0000, 1'b0, 8'h3C);
        tick(2);
        checkOutput("t2_keep_hold", 32'(busA.keep_data), 32'hA5);

        // Owner drops while another rises: one gap, no keeper visit.
        applyStimulus(0, 4'b0001, 1'b0, 8'h00);
        tick(2);
        checkOutput("hand_own0", 32'(busA.grant_en), 32'h1);
        applyStimulus(0, 4'b0010, 1'b0, 8'h00);
        tick(1);
        checkOutput("hand_gap", 32'(busA.grant_en), 32'd0);
        checkOutput("hand_nokeep", 32'(busA.keep_en), 32'd0);
        tick(1);
        checkOutput("hand_own1", 32'(busA.grant_en), 32'h2);
        checkOutput("hand_owner1", 32'(busA.owner), 32'd1);

        // All four requesting: round-robin rotation with gaps.
        doReset();
        applyStimulus(0, 4'b1111, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput($sformatf("rot_grant%0d", i), 32'(busA.grant_en), 32'(rotGrant[i]));
            if (rotGrant[i] != 0)
                checkOutput($sformatf("rot_owner%0d", i), 32'(busA.owner), 32'(rotOwner[i]));
        end

        // Lock blocks preemption; release preempts toward the wrapped pointer.
        doReset();
        applyStimulus(0, 4'b0100, 1'b0, 8'h00);
        tick(2);
        checkOutput("lock_own2", 32'(busA.grant_en), 32'h4);
        applyStimulus(0, 4'b0111, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("lock_hold", 32'(busA.owner), 32'd2);
            checkOutput("lock_grant", 32'(busA.grant_en), 32'h4);
        end
        applyStimulus(0, 4'b0111, 1'b0, 8'h00);
        tick(1);
        checkOutput("unlock_gap", 32'(busA.grant_en), 32'd0);
        tick(1);
        checkOutput("unlock_grant", 32'(busA.grant_en), 32'h1);
        checkOutput("unlock_owner", 32'(busA.owner), 32'd0);

        // Three dead cycles: short pulse never granted, held request granted at n+4.
        doReset();
        applyStimulus(1, 4'b0010, 1'b0, 8'h00);
        tick(2);
        checkOutput("pulse_grant", 32'(busB.grant_en), 32'd0);
        applyStimulus(1, 4'b0000, 1'b0, 8'h00);
        tick(1);
        checkOutput("pulse_dead", 32'(busB.keep_en), 32'd0);
        tick(1);
        checkOutput("pulse_keep", 32'(busB.keep_en), 32'd1);
        checkOutput("pulse_nogrant", 32'(busB.grant_en), 32'd0);
        applyStimulus(1, 4'b0001, 1'b0, 8'h00);
        tick(3);
        checkOutput("lat3_early", 32'(busB.grant_en), 32'd0);
        tick(1);
        checkOutput("lat3_grant", 32'(busB.grant_en), 32'h1);

        // Asynchronous reset while owning.
        doReset();
        applyStimulus(0, 4'b0001, 1'b0, 8'h00);
        tick(2);
        checkOutput("arst_pre", 32'(busA.grant_en), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_grant", 32'(busA.grant_en), 32'd0);
        checkOutput("arst_keep", 32'(busA.keep_en), 32'd1);
        checkOutput("arst_busy", 32'(busA.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 4'b0000, 1'b0, 8'h00);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
